// File: rtl/cache_line_bridge.sv
// cache_line_bridge: moves one 128-bit cache line to/from 16-bit memory as a burst of beats
// (fill, writeback, or writeback then fill). Define CACHE_LINE_BRIDGE_TIMEOUT_EN for the per-beat wait timeout.
module cache_line_bridge #(
    parameter int WORDS_PER_LINE = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_read,
    input  logic                          req_write,
    input  logic [15:0]                   fill_addr,
    input  logic [15:0]                   wb_addr,
    input  logic [16*WORDS_PER_LINE-1:0]  wb_line,
    output logic [16*WORDS_PER_LINE-1:0]  rdata_line,
    output logic                          resp,
    output logic                          busy,
    output logic                          err,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [15:0]                   mem_address,
    output logic [15:0]                   mem_wdata,
    input  logic [15:0]                   mem_rdata,
    input  logic                          mem_resp
);
    localparam int BEAT_W  = $clog2(WORDS_PER_LINE);
    localparam int LINE_W  = 16 * WORDS_PER_LINE;
    localparam int TAG_LSB = BEAT_W + 1;
    localparam int TAG_W   = 16 - TAG_LSB;
    localparam logic [BEAT_W-1:0] FIRST_BEAT = BEAT_W'(0);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [15:0] line_word(input logic [LINE_W-1:0] line, input logic [BEAT_W-1:0] idx);
        line_word = line[int'(idx) * 16 +: 16];
    endfunction

    state_t              state_r;
    logic [BEAT_W-1:0]   beat_r;
    logic [TAG_W-1:0]    wb_tag_r;
    logic [TAG_W-1:0]    fill_tag_r;
    logic [LINE_W-1:0]   wb_line_r;
    logic                fill_pending_r;
    logic [LINE_W-1:0]   rdata_line_r;
    logic                resp_r;
    logic                busy_r;
    logic                mem_read_r;
    logic                mem_write_r;
    logic [15:0]         mem_address_r;
    logic [15:0]         mem_wdata_r;
    logic [BEAT_W-1:0]   beat_nxt_s;
    logic                timeout_s;
    logic                unused_addr_bits_s;

    assign beat_nxt_s         = beat_r + BEAT_W'(1);
    assign unused_addr_bits_s = ^{fill_addr[TAG_LSB-1:0], wb_addr[TAG_LSB-1:0]};

`ifdef CACHE_LINE_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_r;
    logic       err_r;
    logic       in_beat_s;

    assign in_beat_s = (state_r == WB) || (state_r == FILL);
    // Abort fires on the edge where the wait count would reach TIMEOUT_CYCLES.
    assign timeout_s = in_beat_s && !mem_resp && (wait_r == WAIT_LIMIT);

    // Per-beat wait counter: zero outside beats and after every completed beat.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_r <= 8'd0;
        end else if (in_beat_s && !mem_resp && !timeout_s) begin
            wait_r <= wait_r + 8'd1;
        end else begin
            wait_r <= 8'd0;
        end
    end

    // Error flag lines up with the DONE cycle that follows an abort.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= timeout_s;
        end
    end

    assign err = err_r;
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Transfer FSM with registered strobes, beat address/data and assembled line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            beat_r         <= FIRST_BEAT;
            wb_tag_r       <= '0;
            fill_tag_r     <= '0;
            wb_line_r      <= '0;
            fill_pending_r <= 1'b0;
            rdata_line_r   <= '0;
            resp_r         <= 1'b0;
            busy_r         <= 1'b0;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            mem_address_r  <= 16'h0000;
            mem_wdata_r    <= 16'h0000;
        end else begin
            resp_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_write) begin
                        wb_tag_r       <= wb_addr[15:TAG_LSB];
                        wb_line_r      <= wb_line;
                        fill_pending_r <= req_read;
                        if (req_read) begin
                            fill_tag_r <= fill_addr[15:TAG_LSB];
                        end
                        beat_r        <= FIRST_BEAT;
                        mem_write_r   <= 1'b1;
                        mem_address_r <= {wb_addr[15:TAG_LSB], FIRST_BEAT, 1'b0};
                        mem_wdata_r   <= line_word(wb_line, FIRST_BEAT);
                        busy_r        <= 1'b1;
                        state_r       <= WB;
                    end else if (req_read) begin
                        fill_tag_r     <= fill_addr[15:TAG_LSB];
                        fill_pending_r <= 1'b0;
                        beat_r         <= FIRST_BEAT;
                        rdata_line_r   <= '0;
                        mem_read_r     <= 1'b1;
                        mem_address_r  <= {fill_addr[15:TAG_LSB], FIRST_BEAT, 1'b0};
                        busy_r         <= 1'b1;
                        state_r        <= FILL;
                    end
                end
                WB: begin
                    if (mem_resp) begin
                        if (beat_r == LAST_BEAT) begin
                            mem_write_r <= 1'b0;
                            beat_r      <= FIRST_BEAT;
                            if (fill_pending_r) begin
                                fill_pending_r <= 1'b0;
                                rdata_line_r   <= '0;
                                mem_read_r     <= 1'b1;
                                mem_address_r  <= {fill_tag_r, FIRST_BEAT, 1'b0};
                                state_r        <= FILL;
                            end else begin
                                resp_r  <= 1'b1;
                                state_r <= DONE;
                            end
                        end else begin
                            beat_r        <= beat_nxt_s;
                            mem_address_r <= {wb_tag_r, beat_nxt_s, 1'b0};
                            mem_wdata_r   <= line_word(wb_line_r, beat_nxt_s);
                        end
                    end else if (timeout_s) begin
                        mem_write_r    <= 1'b0;
                        fill_pending_r <= 1'b0;
                        resp_r         <= 1'b1;
                        state_r        <= DONE;
                    end
                end
                FILL: begin
                    if (mem_resp) begin
                        rdata_line_r[int'(beat_r) * 16 +: 16] <= mem_rdata;
                        if (beat_r == LAST_BEAT) begin
                            mem_read_r <= 1'b0;
                            beat_r     <= FIRST_BEAT;
                            resp_r     <= 1'b1;
                            state_r    <= DONE;
                        end else begin
                            beat_r        <= beat_nxt_s;
                            mem_address_r <= {fill_tag_r, beat_nxt_s, 1'b0};
                        end
                    end else if (timeout_s) begin
                        mem_read_r <= 1'b0;
                        resp_r     <= 1'b1;
                        state_r    <= DONE;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign rdata_line  = rdata_line_r;
    assign resp        = resp_r;
    assign busy        = busy_r;
    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;
    assign mem_address = mem_address_r;
    assign mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_cache_line_bridge.sv
// Self-checking bench for cache_line_bridge: directed table, reset/timeout sequences and
// randomized requests checked against a line-level memory model.
`timescale 1ns/1ps
module tb_cache_line_bridge;
    localparam int WPL = 8;

    logic         clk = 1'b0;
    logic         reset_n, req_read, req_write;
    logic [15:0]  fill_addr, wb_addr;
    logic [127:0] wb_line, rdata_line;
    logic         resp, busy, err, mem_read, mem_write;
    logic [15:0]  mem_address, mem_wdata, mem_rdata;
    logic         mem_resp;

    always #5 clk = ~clk;

    cache_line_bridge dut (
        .clk(clk), .reset_n(reset_n), .req_read(req_read), .req_write(req_write),
        .fill_addr(fill_addr), .wb_addr(wb_addr), .wb_line(wb_line), .rdata_line(rdata_line),
        .resp(resp), .busy(busy), .err(err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; } beat_t;
    typedef struct { bit rd; bit wr; logic [15:0] fa; logic [15:0] wa; logic [15:0] wbase;
                     int wt; int lat; logic [15:0] first_addr; } vec_t;

    int checks = 0, errors = 0, cyc = 0;
    beat_t log_q[$];
    logic [15:0] mem [0:32767];
    logic [15:0] ref_mem [0:32767];
    logic [127:0] exp_rdata = '0;
    int wait_cfg = 0, wcnt = 0, both_hi = 0;
    bit noise = 0, stuck_en = 0;
    logic [15:0] stuck_addr = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: acts on strobes seen at the falling edge.
    always @(negedge clk) begin
        if (mem_read && mem_write) both_hi++;
        if (mem_read || mem_write) begin
            mem_rdata = mem_read ? mem[mem_address[15:1]] : 16'h0000;
            if ((stuck_en && mem_address == stuck_addr) || wcnt < wait_cfg) begin
                mem_resp = 1'b0;
                wcnt++;
            end else begin
                mem_resp = 1'b1;
                wcnt = 0;
                if (mem_write) begin
                    mem[mem_address[15:1]] = mem_wdata;
                    log_q.push_back('{1'b1, mem_address, mem_wdata});
                end else begin
                    log_q.push_back('{1'b0, mem_address, mem[mem_address[15:1]]});
                end
            end
        end else begin
            wcnt = 0;
            mem_resp  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = noise ? 16'($urandom) : 16'h0000;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_req(input bit rd, input bit wr, input logic [15:0] fa, input logic [15:0] wa,
                           input logic [127:0] wl, input int wt, input int exp_lat, input string tag);
        beat_t exp_q[$];
        logic [15:0] a;
        logic [127:0] line;
        int start, got, bh0;
        bit busy_bad;
        exp_q = {};
        if (wr) begin
            for (int i = 0; i < WPL; i++) begin
                a = (wa & 16'hFFF0) + 16'(2 * i);
                exp_q.push_back('{1'b1, a, wl[16*i +: 16]});
                ref_mem[a[15:1]] = wl[16*i +: 16];
            end
        end
        if (rd) begin
            line = '0;
            for (int i = 0; i < WPL; i++) begin
                a = (fa & 16'hFFF0) + 16'(2 * i);
                exp_q.push_back('{1'b0, a, ref_mem[a[15:1]]});
                line[16*i +: 16] = ref_mem[a[15:1]];
            end
            exp_rdata = line;
        end
        wait_cfg = wt;
        log_q.delete();
        bh0 = both_hi;
        @(posedge clk); #1;
        req_read = rd; req_write = wr; fill_addr = fa; wb_addr = wa; wb_line = wl;
        start = cyc; got = -1; busy_bad = 0;
        for (int k = 0; k < 600 && got < 0; k++) begin
            @(posedge clk); #1;
            if (resp) got = cyc - start;
            else if (!busy) busy_bad = 1;
        end
        chk({tag, " latency"}, 128'(got), 128'(exp_lat));
        chk({tag, " busy during transfer"}, {busy_bad, busy}, {1'b0, 1'b1});
        chk({tag, " done strobes/err"}, {mem_read, mem_write, err}, 3'b000);
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b0;
        chk({tag, " resp one cycle, idle"}, {resp, busy}, 2'b00);
        chk({tag, " beat count"}, 128'(log_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s beat %0d", tag, i), {log_q[i].wr, log_q[i].addr, log_q[i].data},
                {exp_q[i].wr, exp_q[i].addr, exp_q[i].data});
        chk({tag, " rdata_line"}, rdata_line, exp_rdata);
        chk({tag, " strobe exclusion"}, 128'(both_hi), 128'(bh0));
    endtask

    vec_t tbl [4];
    logic [127:0] wl;
    int start, got;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'(i * 2);
            ref_mem[i] = 16'(i * 2);
        end
        reset_n = 1'b0; req_read = 1'b0; req_write = 1'b0;
        fill_addr = 16'h0000; wb_addr = 16'h0000; wb_line = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset rdata_line", rdata_line, 128'h0);
        chk("reset outputs", {resp, busy, err, mem_read, mem_write, mem_address, mem_wdata}, 37'h0);

        tbl[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0000, 0, 9,  16'h1230};
        tbl[1] = '{1'b0, 1'b1, 16'h0000, 16'h8000, 16'hA000, 2, 25, 16'h8000};
        tbl[2] = '{1'b1, 1'b1, 16'h5010, 16'h4000, 16'hB000, 0, 17, 16'h4000};
        tbl[3] = '{1'b1, 1'b1, 16'h4008, 16'h4000, 16'hC000, 1, 33, 16'h4000};
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < WPL; i++) wl[16*i +: 16] = tbl[t].wbase + 16'(i);
            run_req(tbl[t].rd, tbl[t].wr, tbl[t].fa, tbl[t].wa, wl, tbl[t].wt, tbl[t].lat,
                    $sformatf("vec%0d", t));
            if (log_q.size() > 0) chk($sformatf("vec%0d first address", t), log_q[0].addr, tbl[t].first_addr);
            else chk($sformatf("vec%0d first address", t), 128'h1_0000, tbl[t].first_addr);
        end

        // Reset during fill beat 3.
        wait_cfg = 0;
        @(posedge clk); #1;
        req_read = 1'b1; fill_addr = 16'h3000;
        repeat (4) @(posedge clk);
        #1;
        chk("abort beat3 in progress", {mem_read, mem_address}, {1'b1, 16'h3006});
        reset_n = 1'b0; req_read = 1'b0;
        @(posedge clk); #1;
        chk("abort outputs", {resp, busy, mem_read, mem_write, mem_address}, 20'h0);
        chk("abort rdata_line", rdata_line, 128'h0);
        reset_n = 1'b1;
        exp_rdata = '0;
        run_req(1'b1, 1'b0, 16'h3000, 16'h0000, '0, 0, 9, "post-abort fill");

`ifdef CACHE_LINE_BRIDGE_TIMEOUT_EN
        stuck_en = 1'b1; stuck_addr = 16'h2004; wait_cfg = 0;
        @(posedge clk); #1;
        req_read = 1'b1; fill_addr = 16'h2000; start = cyc; got = -1;
        for (int k = 0; k < 600 && got < 0; k++) begin
            @(posedge clk); #1;
            if (resp) got = cyc - start;
        end
        chk("timeout latency", 128'(got), 128'd258);
        chk("timeout resp/err/strobes", {resp, err, mem_read, mem_write}, 4'b1100);
        @(posedge clk); #1;
        req_read = 1'b0;
        chk("timeout pulse ends", {resp, err, busy}, 3'b000);
        exp_rdata = {96'h0, ref_mem[16'h1001], ref_mem[16'h1000]};
        chk("timeout rdata_line", rdata_line, exp_rdata);
        stuck_en = 1'b0;
`endif

        noise = 1'b1;
        for (int n = 0; n < 30; n++) begin
            int sel, wt;
            bit rd, wr;
            logic [15:0] fa, wa;
            sel = $urandom_range(0, 2);
            rd = (sel != 1);
            wr = (sel != 0);
            fa = 16'h6000 + 16'($urandom_range(0, 7) * 16) + 16'($urandom_range(0, 15));
            wa = 16'h6000 + 16'($urandom_range(0, 7) * 16) + 16'($urandom_range(0, 15));
            wl = {$urandom, $urandom, $urandom, $urandom};
            wt = $urandom_range(0, 2);
            run_req(rd, wr, fa, wa, wl, wt, 8 * (int'(rd) + int'(wr)) * (1 + wt) + 1,
                    $sformatf("rand%0d", n));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_line_bridge.md
# cache_line_bridge

Line-transfer engine between the LC-3b cache controller and 16-bit physical memory. It turns one cache request into a sequence of 16-bit memory beats: a 128-bit line fill, a 128-bit dirty-line writeback, or a writeback followed by a fill. It sits directly downstream of the cache control/datapath, on the memory side of the data arrays, and returns one `resp` pulse per request.

## Interface
Parameters:
- `WORDS_PER_LINE`, default 8: 16-bit beats per line; line width is 16*WORDS_PER_LINE = 128.
- `TIMEOUT_CYCLES`, default 255: wait limit per beat; used only when the timeout feature is compiled in.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: reset is synchronous, active-low.
- `req_read` in 1: fill request, line at `fill_addr`.
- `req_write` in 1: writeback request, `wb_line` to `wb_addr`.
- `fill_addr` in 16: fill line byte address; bits [3:0] ignored.
- `wb_addr` in 16: writeback line byte address; bits [3:0] ignored.
- `wb_line` in 128: dirty line; word i is in bits [16i+15:16i].
- `rdata_line` out 128: assembled fill line, same word packing.
- `resp` out 1: one-cycle completion pulse.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: timeout abort flag, valid only while `resp` is high.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_address` out 16: beat byte address.
- `mem_wdata` out 16: beat write data.
- `mem_rdata` in 16: beat read data.
- `mem_resp` in 1: current beat complete.

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE: requests are sampled only here.
  - `req_write` high: latch `wb_addr`/`wb_line`; go to WB.
  - Only `req_read` high: latch `fill_addr`; go to FILL.
  - Both high: latch all three inputs; go to WB, then FILL (eviction sequence).
- Beat counter is 3 bits (log2 WORDS_PER_LINE) and is cleared on entry to WB or FILL.
- Beat address = {latched_addr[15:4], beat, 1'b0}; memory is byte addressed, so beats are 2 bytes apart.
- WB: `mem_write`=1, `mem_wdata`=latched word[beat].
  - On `mem_resp`, beat increments.
  - On `mem_resp` at beat 7: go to FILL if a fill is pending, else DONE.
- FILL: `mem_read`=1.
  - On `mem_resp`, `mem_rdata` is written into `rdata_line` word[beat] and beat increments.
  - On `mem_resp` at beat 7: go to DONE.
- The strobe stays continuously high across beats. `mem_address` and `mem_wdata` change the cycle after each `mem_resp`.
- `mem_read` and `mem_write` are never high together. Both are 0 in IDLE and DONE.
- DONE: `resp`=1 for exactly one cycle, then IDLE. Requests still high in that DONE cycle are ignored.
- The cache must deassert its requests in the cycle after it sees `resp`.
- `rdata_line` is zeroed on entry to FILL and then holds its value until the next FILL entry. It is valid from the `resp` cycle onward.
- `resp` also fires for writeback-only requests; `rdata_line` is unchanged in that case.

## Timing
- Reset (`reset_n`=0 at a rising edge): state IDLE; `rdata_line`, beat counter, timeout counter, latches and all outputs are 0.
- Reset mid-transfer aborts immediately. No `resp` is issued, and the strobes are 0 the cycle after the reset edge.
- Latency with zero-wait memory (`mem_resp` high whenever a strobe is high), with the request arriving in cycle 0:
  - Fill: memory cycles 1–8, `resp` in cycle 9.
  - Writeback: `resp` in cycle 9.
  - Writeback+fill: writes in cycles 1–8, reads in cycles 9–16, `resp` in cycle 17.
- Each memory wait cycle adds one cycle per beat.
- A `mem_resp` arriving in IDLE or DONE is ignored.

## Configuration
- `CACHE_LINE_BRIDGE_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears at each beat start and at each `mem_resp`, and increments while a strobe is high without `mem_resp`.
  - When it reaches TIMEOUT_CYCLES: drop the strobes, discard any pending fill, go to DONE with `resp`=1 and `err`=1.
  - `rdata_line` holds whatever words were written before the abort.
- Not defined: no counter; the bridge waits indefinitely; `err` is tied 0.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, `busy`=0.
- Fill of `fill_addr`=0x1234 with zero-wait memory returning data 0x1230+2i -> `mem_address` 0x1230..0x123E; `resp` at cycle 9; `rdata_line` word i = 0x1230+2i.
- Writeback-only of `wb_addr`=0x8000, `wb_line` word i = 0xA000+i, memory waiting 2 cycles per beat -> 8 writes of 0xA000..0xA007 to 0x8000..0x800E; `resp` at cycle 25; `rdata_line` unchanged.
- Both requests (`wb_addr`=0x4000, `fill_addr`=0x5010) -> all writes complete before the first read; reads go to 0x5010..0x501E; exactly one `resp` at cycle 17.
- `reset_n` low during FILL beat 3 -> IDLE next cycle, no `resp`, strobes 0; a new fill then completes normally.
- With `CACHE_LINE_BRIDGE_TIMEOUT_EN` defined, `mem_resp` stuck low on beat 2 -> strobes drop after 255 wait cycles; `resp`=`err`=1 for one cycle; `rdata_line` words 0–1 hold their data.
